// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry pipeline register with a skid buffer, carrying a PC+4 / instruction
// pair between two pipeline stages.
//
// The "main" entry always drives the outputs. The "skid" entry catches one
// extra beat when the consumer stops after a beat has already been accepted.
// This lets in_ready come straight from a flop instead of from out_ready.
//
// Handshake (both sides): a beat moves on a rising clk edge when its valid and
// ready are both 1 in that cycle. A producer keeps its valid and payload steady
// until the beat is accepted. stall=1 acts exactly like out_ready=0. flush
// discards everything held, plus any beat offered in the same cycle.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : upstream beat present
//   in_ready   : stage can accept a beat this cycle (registered)
//   in_pc      : upstream PC+4
//   in_inst    : upstream instruction
//   flush      : synchronous kill of all held beats
//   stall      : hazard-unit hold of the output beat
//   out_valid  : output beat present
//   out_ready  : downstream accepts
//   out_pc     : held PC+4 (keeps its last value when empty)
//   out_inst   : held instruction; NOP when out_valid=0
//   occupancy  : number of held beats (0..2); this is also the FSM state
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                PC_W   = 32,
    parameter int                INST_W = 32,
    parameter logic [INST_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occupancy
);

    // The state encoding equals the number of held beats, so the state
    // register drives occupancy directly.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_ready_q;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready & ~stall;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            // Flush outranks everything. No payload is loaded, so out_pc
            // keeps its last value and the offered beat is dropped.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt    = TWO;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is 0 here, so only a drain can happen.
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_pc    <= '0;
            main_inst  <= NOP;
            skid_pc    <= '0;
            skid_inst  <= NOP;
        end else begin
            state      <= state_nxt;
            // Ready for the next cycle depends only on whether the skid
            // entry will be free.
            in_ready_q <= (state_nxt != TWO);
            if (load_main_in) begin
                main_pc   <= in_pc;
                main_inst <= in_inst;
            end else if (load_main_skid) begin
                main_pc   <= skid_pc;
                main_inst <= skid_inst;
            end
            if (load_skid_in) begin
                skid_pc   <= in_pc;
                skid_inst <= in_inst;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_pc    = main_pc;
    assign out_inst  = out_valid ? main_inst : NOP;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              flush;
  logic              stall;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [1:0]        occupancy;

  pipe_skid_reg #(.PC_W(PC_W), .INST_W(INST_W), .NOP(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .flush     (flush),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .occupancy (occupancy)
  );

  // vector record: inputs for one cycle, outputs expected after that edge
  typedef struct {
    string             name;
    logic              iv;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fl;
    logic              st;
    logic              ordy;
    logic              e_ov;
    logic [PC_W-1:0]   e_pc;
    logic [INST_W-1:0] e_inst;
    logic              e_ird;
    logic [1:0]        e_occ;
  } vec_t;

  vec_t vecs[$];

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: accepted beats {pc, inst} in arrival order
  logic [PC_W+INST_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic iv, input logic [31:0] pc,
                     input logic [31:0] inst, input logic fl, input logic st,
                     input logic ordy, input logic e_ov, input logic [31:0] e_pc,
                     input logic [31:0] e_inst, input logic e_ird, input logic [1:0] e_occ);
    vec_t v;
    v.name = name; v.iv = iv; v.pc = pc; v.inst = inst; v.fl = fl; v.st = st;
    v.ordy = ordy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_ird = e_ird; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  // driver: apply one cycle of inputs, wait for the edge, settle
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic fl, input logic st, input logic ordy);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    flush     = fl;
    stall     = st;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name, input logic ov, input logic [31:0] pc,
                          input logic [31:0] inst, input logic ird, input logic [1:0] occ);
    chk({name, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({name, ".out_pc"},    64'(out_pc),    64'(pc));
    chk({name, ".out_inst"},  64'(out_inst),  64'(inst));
    chk({name, ".in_ready"},  64'(in_ready),  64'(ird));
    chk({name, ".occupancy"}, 64'(occupancy), 64'(occ));
  endtask

  initial begin
    // ---- vector table ----
    // stream: 8 beats, visible one cycle later, state stays ONE
    for (int i = 0; i < 8; i++)
      add("stream", 1, 4*i+4, 32'h100+i, 0, 0, 1, 1, 4*i+4, 32'h100+i, 1, 1);
    add("stream_drain", 0, 0, 0, 0, 0, 1, 0, 32, NOP, 1, 0);
    // backpressure: 3 beats offered with out_ready=0
    add("bp_b0",   1, 32'h40, 32'h200, 0, 0, 0, 1, 32'h40, 32'h200, 1, 1);
    add("bp_b1",   1, 32'h44, 32'h201, 0, 0, 0, 1, 32'h40, 32'h200, 0, 2);
    add("bp_b2",   1, 32'h48, 32'h202, 0, 0, 0, 1, 32'h40, 32'h200, 0, 2);
    add("bp_rel0", 1, 32'h48, 32'h202, 0, 0, 1, 1, 32'h44, 32'h201, 1, 1);
    add("bp_rel1", 1, 32'h48, 32'h202, 0, 0, 1, 1, 32'h48, 32'h202, 1, 1);
    add("bp_rel2", 0, 0, 0, 0, 0, 1, 0, 32'h48, NOP, 1, 0);
    // stall holds the beat in ONE even with out_ready=1
    add("st_load", 1, 32'h50, 32'hAA, 0, 0, 0, 1, 32'h50, 32'hAA, 1, 1);
    for (int i = 0; i < 3; i++)
      add("stall", 0, 0, 0, 0, 1, 1, 1, 32'h50, 32'hAA, 1, 1);
    add("st_rel", 0, 0, 0, 0, 0, 1, 0, 32'h50, NOP, 1, 0);
    // stall in TWO: nothing moves
    add("st2_a", 1, 32'h58, 32'hB0, 0, 1, 1, 1, 32'h58, 32'hB0, 1, 1);
    add("st2_b", 1, 32'h5C, 32'hB1, 0, 1, 1, 1, 32'h58, 32'hB0, 0, 2);
    add("st2_c", 0, 0, 0, 0, 1, 1, 1, 32'h58, 32'hB0, 0, 2);
    add("st2_d", 0, 0, 0, 0, 0, 1, 1, 32'h5C, 32'hB1, 1, 1);
    add("st2_e", 0, 0, 0, 0, 0, 1, 0, 32'h5C, NOP, 1, 0);
    // flush in TWO with a beat offered and stall high: flush wins
    add("fl_a",  1, 32'h60, 32'h300, 0, 0, 0, 1, 32'h60, 32'h300, 1, 1);
    add("fl_b",  1, 32'h64, 32'h301, 0, 0, 0, 1, 32'h60, 32'h300, 0, 2);
    add("fl_c",  1, 32'h68, 32'h302, 1, 1, 1, 0, 32'h60, NOP, 1, 0);
    add("fl_d",  0, 0, 0, 0, 0, 1, 0, 32'h60, NOP, 1, 0);
    // flush in ONE with same-cycle in_fire and out_fire
    add("fl1_a", 1, 32'h70, 32'h303, 0, 0, 1, 1, 32'h70, 32'h303, 1, 1);
    add("fl1_b", 1, 32'h74, 32'h304, 1, 0, 1, 0, 32'h70, NOP, 1, 0);
    add("fl1_c", 0, 0, 0, 0, 0, 1, 0, 32'h70, NOP, 1, 0);

    // ---- reset state ----
    reset = 1'b1;
    in_valid = 0; in_pc = '0; in_inst = '0; flush = 0; stall = 0; out_ready = 0;
    #2;
    chk_outs("reset", 0, 0, NOP, 1, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table ----
    foreach (vecs[k]) begin
      drive(vecs[k].iv, vecs[k].pc, vecs[k].inst, vecs[k].fl, vecs[k].st, vecs[k].ordy);
      chk_outs(vecs[k].name, vecs[k].e_ov, vecs[k].e_pc, vecs[k].e_inst,
               vecs[k].e_ird, vecs[k].e_occ);
    end

    // ---- async reset between edges while in TWO ----
    drive(1, 32'h80, 32'h400, 0, 0, 0);
    drive(1, 32'h84, 32'h401, 0, 0, 0);
    chk_outs("ar_two", 1, 32'h80, 32'h400, 0, 2);
    #2 reset = 1'b1;
    #1;
    chk_outs("ar_async", 0, 0, NOP, 1, 0);
    #1 reset = 1'b0;
    // first edge after reset behaves as EMPTY; skid beat must be gone
    drive(1, 32'h88, 32'h402, 0, 0, 0);
    chk_outs("ar_after", 1, 32'h88, 32'h402, 1, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk_outs("ar_drain", 0, 32'h88, NOP, 1, 0);

    // ---- random traffic against a queue scoreboard ----
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv, fl, st, ordy, fire_in, fire_out;
      logic [31:0] pc, inst;
      logic [PC_W+INST_W-1:0] head;
      iv   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      st   = ($urandom_range(0, 4) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      pc   = $urandom;
      inst = $urandom;
      fire_in  = iv && (exp_q.size() < 2);
      fire_out = (exp_q.size() > 0) && ordy && !st;
      drive(iv, pc, inst, fl, st, ordy);
      if (fl) exp_q.delete();
      else begin
        if (fire_out) void'(exp_q.pop_front());
        if (fire_in) exp_q.push_back({pc, inst});
      end
      chk("rnd.occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("rnd.in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("rnd.out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        chk("rnd.out_pc", 64'(out_pc), 64'(head[PC_W+INST_W-1:INST_W]));
        chk("rnd.out_inst", 64'(out_inst), 64'(head[INST_W-1:0]));
      end else begin
        chk("rnd.out_inst_nop", 64'(out_inst), 64'(NOP));
      end
    end

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: PC_W, 32, width of the PC+4 payload field.
REQ-002 Parameter: INST_W, 32, width of the instruction payload field.
REQ-003 Parameter: NOP, 32'h0000_0000 (INST_W bits), instruction value presented while empty or flushed.
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: in_valid  in  1  upstream beat present.
REQ-007 Port: in_ready  out  1  stage accepts a beat this cycle; driven only from flops.
REQ-008 Port: in_pc  in  PC_W  upstream PC+4.
REQ-009 Port: in_inst  in  INST_W  upstream instruction.
REQ-010 Port: flush  in  1  synchronous kill of all held beats.
REQ-011 Port: stall  in  1  hazard-unit hold of the output beat.
REQ-012 Port: out_valid  out  1  output beat present.
REQ-013 Port: out_ready  in  1  downstream accepts.
REQ-014 Port: out_pc  out  PC_W  held PC+4.
REQ-015 Port: out_inst  out  INST_W  held instruction; NOP when out_valid=0.
REQ-016 Port: occupancy  out  2  number of held beats (0..2).

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; states EMPTY (0), ONE (main valid), TWO (main+skid valid).
REQ-018 Accept event: in_fire = in_valid & in_ready; in_ready SHALL equal 1 in EMPTY/ONE, 0 in TWO.
REQ-019 Drain event: out_fire = out_valid & out_ready & ~stall; stall=1 SHALL act as out_ready=0.
REQ-020 EMPTY: in_fire -> ONE, main loads input; beat visible on outputs next cycle (latency 1).
REQ-021 ONE: in_fire & out_fire -> ONE, main loads input; in_fire only -> TWO, skid loads input; out_fire only -> EMPTY.
REQ-022 TWO: out_fire -> ONE, main loads skid; no input accepted in TWO.
REQ-023 Beats SHALL leave in arrival order; no beat duplicated or dropped except by flush.
REQ-024 flush=1 SHALL, at the next edge, go to EMPTY, clear both valid bits, set out_inst to NOP, and discard any same-cycle input beat; flush has priority over stall, in_fire, out_fire.
REQ-025 Flush with stall=1 simultaneously: flush wins; result EMPTY.
REQ-026 out_pc SHALL retain its last value when empty (don't-care for consumers); out_inst SHALL be NOP whenever out_valid=0.
REQ-027 Payload SHALL not change while out_valid=1 and out_fire=0.
REQ-028 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-029 Full-rate streaming (in_valid=1, out_ready=1, stall=0) SHALL sustain one beat per cycle with state staying ONE.

Reset
REQ-030 reset=1 SHALL immediately, independent of clk: out_valid=0, out_inst=NOP, out_pc=0, skid cleared, in_ready=1, occupancy=0, state EMPTY.
REQ-031 Reset asserted mid-operation (state TWO) SHALL discard both beats; first edge after deassertion behaves as EMPTY.

Verification
REQ-032 Stream: 8 beats inst=0x100+i, pc=4i+4, out_ready=1 -> outputs appear 1 cycle later, in order, out_valid continuous, occupancy=1.
REQ-033 Backpressure: out_ready=0 while 3 beats offered -> beat0 in main, beat1 in skid, in_ready=0 after 2nd accept, occupancy=2; release -> beat0, beat1, beat2 in order.
REQ-034 Stall: in state ONE holding inst=0xAA, stall=1 with out_ready=1 for 3 cycles -> out_inst=0xAA, out_valid=1 stable, no drain.
REQ-035 Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_inst=NOP, occupancy=0, in_ready=1; offered beat never appears.
REQ-036 Async reset pulse between edges in TWO -> outputs reset values immediately, before next clk edge.
REQ-037 Random valid/ready/stall/flush, 10k cycles -> scoreboard: output sequence equals input sequence minus flushed beats; in_ready=0 only when occupancy=2.
